// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   - 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   - packed BTB entry; tag/target are stored at BP_MAX_XLEN and zero-extended,
//     so one typedef serves every XLEN up to 64
//   - index/tag extraction helpers; idx = pc[idx_w+1:2], tag = pc >> (idx_w+2)
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int BP_MAX_XLEN = 64;

  typedef logic [BP_MAX_XLEN-1:0] bp_word_t;

  typedef struct packed {
    logic       valid;
    bp_word_t   tag;
    bp_word_t   target;
    logic       is_jump;
    logic [1:0] ctr;
  } btb_entry_t;

  function automatic bp_word_t bp_idx(input bp_word_t pc, input int idx_w);
    return (pc >> 2) & ((bp_word_t'(1) << idx_w) - bp_word_t'(1));
  endfunction

  function automatic bp_word_t bp_tag(input bp_word_t pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor bundle.
//   IF side : if_valid, if_pc -> pred_taken, pred_target, pred_ghr
//   ID side : upd_* resolution -> redirect_valid, redirect_pc
//   Stats   : cnt_lookups, cnt_mispred
// master = pipeline, slave = predictor.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 6
);
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;

  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_is_branch;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic [GHR_W-1:0] upd_ghr;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [31:0]      cnt_lookups;
  logic [31:0]      cnt_mispred;

  modport master (
    output if_valid, if_pc,
    output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target, upd_ghr,
    input  pred_taken, pred_target, pred_ghr,
    input  redirect_valid, redirect_pc, cnt_lookups, cnt_mispred
  );

  modport slave (
    input  if_valid, if_pc,
    input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target, upd_ghr,
    output pred_taken, pred_target, pred_ghr,
    output redirect_valid, redirect_pc, cnt_lookups, cnt_mispred
  );
endinterface

// File: rtl/bp_ctr2.sv
// 2-bit saturating direction counter next-state.
//   ctr_i   : current counter
//   taken_i : resolved outcome
//   ctr_o   : counter moved one step toward the outcome, clamped at SNT/ST
module bp_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB looked up in IF, trained from
// the ID-stage resolution, with mispredict redirect and saturating counters.
//   clock, rst_n : clock, async active-low reset
//   bp (slave)   : lookup, update, redirect and counter signals
// Optional feature macro BP_GSHARE_EN: direction from a gshare PHT indexed by
// idx ^ ghr instead of the per-entry BTB counter. Ports identical either way.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int GHR_W   = 6
) (
  input  logic              clock,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);

  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("ENTRIES must be a power of two >= 4");
  end
  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
    $error("GHR_W must be in 1..log2(ENTRIES)");
  end
  if (XLEN > BP_MAX_XLEN) begin : g_bad_xlen
    $error("XLEN exceeds BP_MAX_XLEN");
  end

  localparam btb_entry_t BTB_RST = '{valid: 1'b0, tag: '0, target: '0,
                                     is_jump: 1'b0, ctr: WNT};

  btb_entry_t btb_q [ENTRIES];
  logic [31:0] cnt_lookups_q, cnt_lookups_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  // ---- lookup (zero latency, from registered state) ----
  logic [IDX_W-1:0] l_idx, u_idx;
  bp_word_t         l_tag, u_tag;
  logic             l_hit, u_tag_match, u_hit;
  logic [1:0]       l_ctr, u_ctr, u_ctr_nxt, btb_ctr_nxt;

  assign l_idx       = IDX_W'(bp_idx(bp_word_t'(bp.if_pc), IDX_W));
  assign l_tag       = bp_tag(bp_word_t'(bp.if_pc), IDX_W);
  assign l_hit       = btb_q[l_idx].valid && (btb_q[l_idx].tag == l_tag);

  assign u_idx       = IDX_W'(bp_idx(bp_word_t'(bp.upd_pc), IDX_W));
  assign u_tag       = bp_tag(bp_word_t'(bp.upd_pc), IDX_W);
  assign u_tag_match = (btb_q[u_idx].tag == u_tag);
  assign u_hit       = btb_q[u_idx].valid && u_tag_match;

  bp_ctr2 u_ctr2 (.ctr_i(u_ctr), .taken_i(bp.upd_taken), .ctr_o(u_ctr_nxt));

`ifdef BP_GSHARE_EN
  logic [1:0]       pht_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic [IDX_W-1:0] l_pidx, u_pidx;
  logic             unused_btb_ctr;

  assign l_pidx         = l_idx ^ IDX_W'(ghr_q);
  assign u_pidx         = u_idx ^ IDX_W'(bp.upd_ghr);
  assign l_ctr          = pht_q[l_pidx];
  assign u_ctr          = pht_q[u_pidx];
  assign btb_ctr_nxt    = btb_q[u_idx].ctr;  // BTB counter is dormant here
  assign unused_btb_ctr = ^btb_q[l_idx].ctr;
  assign bp.pred_ghr    = ghr_q;

  // History is trained at resolution, so it never needs speculative repair.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WNT;
      ghr_q <= '0;
    end else if (bp.upd_valid && bp.upd_is_branch) begin
      pht_q[u_pidx] <= u_ctr_nxt;
      ghr_q         <= GHR_W'({ghr_q, bp.upd_taken});
    end
  end
`else
  logic unused_ghr;

  assign l_ctr       = btb_q[l_idx].ctr;
  assign u_ctr       = btb_q[u_idx].ctr;
  assign btb_ctr_nxt = u_ctr_nxt;
  assign unused_ghr  = ^bp.upd_ghr;
  assign bp.pred_ghr = '0;
`endif

  assign bp.pred_taken  = l_hit && (btb_q[l_idx].is_jump || l_ctr[1]);
  assign bp.pred_target = bp.pred_taken ? XLEN'(btb_q[l_idx].target)
                                        : bp.if_pc + XLEN'(4);

  // ---- resolution / redirect ----
  logic is_cti, mispredict;
  assign is_cti     = bp.upd_is_branch || bp.upd_is_jump;
  assign mispredict = bp.upd_valid &&
                      ((bp.upd_pred_taken != bp.upd_taken) ||
                       (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

  // Gated by rst_n so a flush is never requested while the core is in reset.
  assign bp.redirect_valid = mispredict && rst_n;
  assign bp.redirect_pc    = (is_cti && bp.upd_taken) ? bp.upd_target
                                                      : bp.upd_pc + XLEN'(4);

  // ---- BTB training ----
  logic       wr_en;
  btb_entry_t wr_ent;

  always_comb begin
    wr_en  = 1'b0;
    wr_ent = btb_q[u_idx];
    if (bp.upd_valid) begin
      if (is_cti) begin
        if (u_hit) begin
          wr_en      = 1'b1;
          wr_ent.ctr = btb_ctr_nxt;
          if (bp.upd_taken) wr_ent.target = bp_word_t'(bp.upd_target);
        end else if (bp.upd_taken) begin
          wr_en  = 1'b1;
          wr_ent = '{valid: 1'b1, tag: u_tag, target: bp_word_t'(bp.upd_target),
                     is_jump: bp.upd_is_jump, ctr: WT};
        end
      end else if (bp.upd_pred_taken && u_tag_match) begin
        // Non-CTI predicted taken: the entry aliases this PC, drop it.
        wr_en        = 1'b1;
        wr_ent.valid = 1'b0;
      end
    end
  end

  // ---- statistics ----
  always_comb begin
    cnt_lookups_d = cnt_lookups_q;
    cnt_mispred_d = cnt_mispred_q;
    if (bp.if_valid && (cnt_lookups_q != '1)) cnt_lookups_d = cnt_lookups_q + 32'd1;
    if (mispredict && (cnt_mispred_q != '1))  cnt_mispred_d = cnt_mispred_q + 32'd1;
  end

  assign bp.cnt_lookups = cnt_lookups_q;
  assign bp.cnt_mispred = cnt_mispred_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= BTB_RST;
      cnt_lookups_q <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (wr_en) btb_q[u_idx] <= wr_ent;
      cnt_lookups_q <= cnt_lookups_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, XLEN=32).
module tb_branch_predictor;
  localparam int XLEN  = 32;
  localparam int GHR_W = 6;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  branch_predictor_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bus ();

  branch_predictor #(.XLEN(XLEN), .ENTRIES(64), .GHR_W(GHR_W)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bp    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic isb, input logic isj,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_is_branch   = isb;
    bus.upd_is_jump     = isj;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic clr_upd;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_is_branch   = 1'b0;
    bus.upd_is_jump     = 1'b0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    bus.upd_ghr         = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc = 32'h40;
    clr_upd();
    #2;
    n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken: got %b want 0", bus.pred_taken); end
    n_chk++; if (bus.pred_target !== 32'h44) begin n_fail++; $display("FAIL rst_pred_target: got %h want 00000044", bus.pred_target); end
    n_chk++; if (bus.pred_ghr !== '0) begin n_fail++; $display("FAIL rst_pred_ghr: got %h want 0", bus.pred_ghr); end
    n_chk++; if (bus.cnt_lookups !== 32'd0 || bus.cnt_mispred !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.cnt_lookups, bus.cnt_mispred); end
    tick(); tick();
    rst_n = 1'b1;
    bus.if_valid = 1'b1;
    tick(); tick(); tick();
    bus.if_valid = 1'b0;
    n_chk++; if (bus.cnt_lookups !== 32'd3) begin n_fail++; $display("FAIL cnt_lookups: got %0d want 3", bus.cnt_lookups); end
  endtask

  task automatic test_train_taken;
    bus.if_pc = 32'h40;
    set_upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100) begin n_fail++; $display("FAIL train_redirect: got %b/%h want 1/00000100", bus.redirect_valid, bus.redirect_pc); end
    n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_no_bypass: got %b want 0", bus.pred_taken); end
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100) begin n_fail++; $display("FAIL train_lookup: got %b/%h want 1/00000100", bus.pred_taken, bus.pred_target); end
    n_chk++; if (bus.cnt_mispred !== 32'd1) begin n_fail++; $display("FAIL train_cnt: got %0d want 1", bus.cnt_mispred); end
  endtask

  task automatic test_not_taken;
    bus.if_pc = 32'h40;
    // ctr 2 -> 1
    set_upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h44) begin n_fail++; $display("FAIL nt1_redirect: got %b/%h want 1/00000044", bus.redirect_valid, bus.redirect_pc); end
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin n_fail++; $display("FAIL nt1_lookup: got %b/%h want 0/00000044", bus.pred_taken, bus.pred_target); end
    // ctr 1 -> 0, correctly predicted
    set_upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h44);
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL nt2_redirect: got %b want 0", bus.redirect_valid); end
    tick();
    // ctr 0 -> 1: still not-taken only if it really held at 0
    set_upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_saturate: got %b want 0", bus.pred_taken); end
    // ctr 1 -> 2
    set_upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100) begin n_fail++; $display("FAIL nt_retrain: got %b/%h want 1/00000100", bus.pred_taken, bus.pred_target); end
    n_chk++; if (bus.cnt_mispred !== 32'd4) begin n_fail++; $display("FAIL nt_cnt: got %0d want 4", bus.cnt_mispred); end
  endtask

  task automatic test_alias;
    bus.if_pc = 32'h140;
    #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h144) begin n_fail++; $display("FAIL alias_miss: got %b/%h want 0/00000144", bus.pred_taken, bus.pred_target); end
    set_upd(32'h140, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h144);
    #1;
    n_chk++; if (bus.redirect_pc !== 32'h200) begin n_fail++; $display("FAIL alias_redirect: got %h want 00000200", bus.redirect_pc); end
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin n_fail++; $display("FAIL alias_jal_hit: got %b/%h want 1/00000200", bus.pred_taken, bus.pred_target); end
    bus.if_pc = 32'h40;
    #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin n_fail++; $display("FAIL alias_evicted: got %b/%h want 0/00000044", bus.pred_taken, bus.pred_target); end
  endtask

  task automatic test_invalidate;
    bus.if_pc = 32'h40;
    set_upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL inv_setup: got %b want 1", bus.pred_taken); end
    set_upd(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h44) begin n_fail++; $display("FAIL inv_redirect: got %b/%h want 1/00000044", bus.redirect_valid, bus.redirect_pc); end
    tick(); clr_upd(); #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin n_fail++; $display("FAIL inv_lookup: got %b/%h want 0/00000044", bus.pred_taken, bus.pred_target); end
  endtask

  task automatic test_wrap;
    bus.if_pc = 32'hFFFF_FFFC;
    set_upd(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000);
    #1;
    n_chk++; if (bus.pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_pred_target: got %h want 00000000", bus.pred_target); end
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_redirect: got %b/%h want 1/00000000", bus.redirect_valid, bus.redirect_pc); end
    tick(); clr_upd();
  endtask

  task automatic test_back_to_back;
    set_upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h304);
    tick();
    bus.if_pc = 32'h300;
    set_upd(32'h304, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h308);
    #1;
    n_chk++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h400) begin n_fail++; $display("FAIL b2b_first: got %b/%h want 1/00000400", bus.pred_taken, bus.pred_target); end
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h500) begin n_fail++; $display("FAIL b2b_redirect: got %b/%h want 1/00000500", bus.redirect_valid, bus.redirect_pc); end
    tick();
    bus.if_pc = 32'h304;
    set_upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h480, 1'b1, 32'h400);
    #1;
    n_chk++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h500) begin n_fail++; $display("FAIL b2b_second: got %b/%h want 1/00000500", bus.pred_taken, bus.pred_target); end
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h480) begin n_fail++; $display("FAIL b2b_wrong_target: got %b/%h want 1/00000480", bus.redirect_valid, bus.redirect_pc); end
    tick();
    bus.if_pc = 32'h300;
    set_upd(32'h300, 1'b0, 1'b1, 1'b1, 32'h480, 1'b1, 32'h480);
    #1;
    n_chk++; if (bus.pred_target !== 32'h480) begin n_fail++; $display("FAIL b2b_new_target: got %h want 00000480", bus.pred_target); end
    n_chk++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_correct: got %b want 0", bus.redirect_valid); end
    tick(); clr_upd(); #1;
    n_chk++; if (bus.cnt_mispred !== 32'd11 || bus.cnt_lookups !== 32'd3) begin n_fail++; $display("FAIL b2b_counters: got %0d/%0d want 11/3", bus.cnt_mispred, bus.cnt_lookups); end
  endtask

  task automatic test_reset_mid_update;
    set_upd(32'h600, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h604);
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", bus.redirect_valid); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL mid_redirect: got %b want 0", bus.redirect_valid); end
    n_chk++; if (bus.cnt_mispred !== 32'd0 || bus.cnt_lookups !== 32'd0) begin n_fail++; $display("FAIL mid_counters: got %0d/%0d want 0/0", bus.cnt_mispred, bus.cnt_lookups); end
    tick(); clr_upd(); tick();
    rst_n = 1'b1;
    bus.if_pc = 32'h600;
    #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h604) begin n_fail++; $display("FAIL mid_no_write: got %b/%h want 0/00000604", bus.pred_taken, bus.pred_target); end
    bus.if_pc = 32'h300;
    #1;
    n_chk++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h304) begin n_fail++; $display("FAIL mid_cleared: got %b/%h want 0/00000304", bus.pred_taken, bus.pred_target); end
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare;
    logic [31:0] snap;
    logic        tk;
    snap = '0;
    bus.if_pc = 32'h80;
    for (int i = 0; i < 40; i++) begin
      tk = (i % 2) == 0;
      #1;
      set_upd(32'h80, 1'b1, 1'b0, tk, 32'h100, bus.pred_taken, bus.pred_target);
      bus.upd_ghr = bus.pred_ghr;
      tick();
      if (i == 23) snap = bus.cnt_mispred;
    end
    clr_upd(); #1;
    n_chk++; if (bus.cnt_mispred !== snap) begin n_fail++; $display("FAIL gshare_steady: got %0d want %0d", bus.cnt_mispred, snap); end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_train_taken();
    test_not_taken();
    test_alias();
    test_invalidate();
    test_wrap();
    test_back_to_back();
    test_reset_mid_update();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the next-generation 5-stage RV32 pipeline. It replaces the current resolve-in-ID-then-flush scheme with prediction in IF. A direct-mapped BTB holds tag, target, type and a 2-bit direction counter. The block is trained from the ID-stage resolution, raises a redirect on misprediction, and keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 32, data/PC width
- ENTRIES, 64, BTB entries; power of two, ≥ 4
- GHR_W, 6, global history width; only used with gshare; 1 ≤ GHR_W ≤ log2(ENTRIES)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF stage presents a PC this cycle
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  predicted taken (combinational from state)
- pred_target  out  XLEN  predicted next PC
- pred_ghr  out  GHR_W  history used for this prediction; 0 without gshare
- upd_valid  in  1  ID stage resolves an instruction this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  jal/jalr
- upd_taken  in  1  actual outcome; forced 1 by the pipeline for jumps
- upd_target  in  XLEN  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  XLEN  predicted target carried down the pipe
- upd_ghr  in  GHR_W  pred_ghr carried down the pipe; ignored without gshare
- redirect_valid  out  1  mispredict; flush IF/ID and load redirect_pc
- redirect_pc  out  XLEN  corrected PC
- cnt_lookups  out  32  saturating count of if_valid cycles
- cnt_mispred  out  32  saturating count of redirect_valid cycles

## Operation
- IDX_W = log2(ENTRIES). idx = pc[IDX_W+1:2]. tag = pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target, is_jump, ctr[1:0].
- Lookup: hit = valid && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4.
  - Outputs are valid regardless of if_valid. if_valid only gates cnt_lookups.
- Update applies when upd_valid:
  - Branch/jump, BTB hit on upd_pc:
    - taken: ctr saturates up to 3 and target <= upd_target.
    - not taken: ctr saturates down to 0. Target is kept.
  - Branch/jump, miss:
    - taken: allocate, overwriting the slot. valid=1, tag, target, is_jump=upd_is_jump, ctr=2 (weakly taken).
    - not taken: no allocation.
  - Neither branch nor jump, but upd_pred_taken: invalidate the entry if its tag matches (alias cleanup).
- Mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)). A non-branch predicted taken counts as a mispredict.
- redirect_valid = mispredict, combinational.
- redirect_pc = (branch/jump && upd_taken) ? upd_target : upd_pc+4.
- Both counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Lookup has zero latency. The result comes from the state registered at the last edge.
- Training writes at the rising edge after upd_valid and is visible to lookups from the next cycle.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update state. No bypass.
- Reset (async assert, any time including mid-update):
  - all entries valid=0, ctr=1, ghr=0, counters=0.
  - The pending update is discarded.
  - pred_taken=0, pred_target=if_pc+4, redirect_valid=0, pred_ghr=0.
- PC+4 arithmetic is modulo 2^XLEN: PC 32'hFFFF_FFFC wraps to 0.

## Configuration
- BP_GSHARE_EN defined:
  - Direction comes from a separate PHT of ENTRIES 2-bit counters (reset 1), indexed by idx XOR zero-extended ghr. BTB ctr is unused.
  - Update indexes the PHT with upd_pc idx XOR upd_ghr.
  - ghr <= {ghr[GHR_W-2:0], upd_taken} on every upd_valid && upd_is_branch. The update is non-speculative, so no recovery is needed.
  - pred_ghr = ghr.
- BP_GSHARE_EN undefined: bimodal counters in the BTB. No ghr register, pred_ghr = 0, upd_ghr ignored. Ports are identical in both builds.

## Structure
- Shared package bp_pkg holds:
  - counter constants SNT=0, WNT=1, WT=2, ST=3;
  - the packed BTB entry typedef;
  - idx/tag extraction functions.
- Sub-module bp_ctr2: 2-bit saturating update (ctr, taken → next ctr). Used by both the BTB and PHT paths.

## Test plan
- Reset, then if_pc=0x40: pred_taken=0, pred_target=0x44, both counters 0.
- Resolve branch at 0x40 taken to 0x100, upd_pred_taken=0: redirect_valid=1, redirect_pc=0x100. Next cycle lookup 0x40 gives pred_taken=1, pred_target=0x100.
- Same branch resolved not-taken twice (ctr 2→1→0):
  - first: redirect_pc=0x44;
  - after the first, pred_taken=0;
  - second: ctr saturates at 0.
- Alias test with ENTRIES=64: 0x40 and 0x140 share idx with different tags.
  - 0x140 misses.
  - A jal at 0x140 taken to 0x200 overwrites the slot.
  - 0x40 then misses.
- Non-branch at 0x40 with upd_pred_taken=1: redirect_pc=0x44 and the entry is invalidated.
- Assert rst_n mid-update with upd_valid=1: no entry written, redirect_valid=0, cnt_mispred=0.
- BP_GSHARE_EN build: alternating T/NT branch at 0x80. After warm-up the mispredict count stops increasing.
